shiftl_pipe: RTL

//   Pipelined barrel left shifter, companion to the ALU right-shift unit.

---
 rtl/shiftl_pkg.sv | 33 +++
 rtl/shiftl_if.sv | 27 ++
 rtl/shiftl_level.sv | 17 +
 rtl/shiftl_pipe.sv | 122 ++++++++++++
 4 files changed

// File: rtl/shiftl_pkg.sv
// Shared ALU shift opcodes and the op-class decode used by the left shifter.
// SHIFTL_ROTATE_EN adds the ROL class; without it ROL decodes as pass-through.
package shiftl_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_SLL = 4'b0001;
  localparam logic [OP_W-1:0] ALU_SRL = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SRA = 4'b0011;
  localparam logic [OP_W-1:0] ALU_ROL = 4'b0101;

  typedef enum logic [1:0] {
    CLS_PASS,
    CLS_SLL,
    CLS_ROL
  } shift_cls_e;

  function automatic shift_cls_e decode_op(input logic [OP_W-1:0] op);
    shift_cls_e cls;
    cls = CLS_PASS;
    case (op)
      ALU_SLL: cls = CLS_SLL;
`ifdef SHIFTL_ROTATE_EN
      ALU_ROL: cls = CLS_ROL;
`endif
      // Right shifts belong to the companion unit; here they just flow through.
      ALU_SRL, ALU_SRA: cls = CLS_PASS;
      default: cls = CLS_PASS;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/shiftl_if.sv
// Upstream op / downstream result handshake bundle of the left shifter.
interface shiftl_if
  import shiftl_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             valid_i;
  logic             ready_o;
  logic [OP_W-1:0]  alu_op_i;
  logic [WIDTH-1:0] alu_a_i;
  logic [WIDTH-1:0] alu_b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] alu_p_o;

  modport slave (
    input  valid_i, alu_op_i, alu_a_i, alu_b_i, ready_i,
    output ready_o, valid_o, alu_p_o
  );

  modport master (
    output valid_i, alu_op_i, alu_a_i, alu_b_i, ready_i,
    input  ready_o, valid_o, alu_p_o
  );

endinterface

// File: rtl/shiftl_level.sv
// One combinational shift-left-by-AMT level; rot feeds the shifted-out MSBs back in at the LSBs.
module shiftl_level #(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] src_dat,
  input  logic             en,
  input  logic             rot,
  output logic [WIDTH-1:0] res_dat
);

  logic [AMT-1:0] fill;

  assign fill    = rot ? src_dat[WIDTH-1 -: AMT] : '0;
  assign res_dat = en ? {src_dat[WIDTH-AMT-1:0], fill} : src_dat;

endmodule

// File: rtl/shiftl_pipe.sv
// Two-stage barrel left shifter (SLL, ROL under SHIFTL_ROTATE_EN), 2-cycle latency, 1 op/cycle.
// Stages hold under downstream backpressure; ready_o depends only on stage valids and ready_i.
module shiftl_pipe
  import shiftl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPLIT = 3
) (
  input logic     clk_i,
  input logic     rst_i,
  shiftl_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int HI_W    = SHAMT_W - SPLIT;

  typedef struct packed {
    logic             vld;
    logic             shift;
`ifdef SHIFTL_ROTATE_EN
    logic             rot;
`endif
    logic [HI_W-1:0]  shamt;
    logic [WIDTH-1:0] dat;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
  } s2_t;

  s1_t s1_q;
  s2_t s2_q;

  logic s2_load;

  assign s2_load     = !s2_q.vld || bus.ready_i;
  assign bus.ready_o = !s1_q.vld || s2_load;

  shift_cls_e         in_cls;
  logic               in_shift;
  logic               in_rot;
  logic               s1_rot;
  logic [SHAMT_W-1:0] in_shamt;
  logic               unused_b_hi;

  assign in_cls      = decode_op(bus.alu_op_i);
  assign in_shift    = (in_cls != CLS_PASS);
  assign in_shamt    = bus.alu_b_i[SHAMT_W-1:0];
  assign unused_b_hi = ^bus.alu_b_i[WIDTH-1:SHAMT_W];

`ifdef SHIFTL_ROTATE_EN
  assign in_rot = (in_cls == CLS_ROL);
  assign s1_rot = s1_q.rot;
`else
  assign in_rot = 1'b0;
  assign s1_rot = 1'b0;
`endif

  // Low shift levels resolve ahead of the stage-1 register.
  logic [SPLIT:0][WIDTH-1:0] lvl1;
  assign lvl1[0] = bus.alu_a_i;

  for (genvar g = 0; g < SPLIT; g++) begin : g_lvl1
    shiftl_level #(
      .WIDTH (WIDTH),
      .AMT   (1 << g)
    ) u_lvl (
      .src_dat (lvl1[g]),
      .en      (in_shift && in_shamt[g]),
      .rot     (in_rot),
      .res_dat (lvl1[g+1])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
    end else if (bus.ready_o) begin
      s1_q.vld <= bus.valid_i;
      if (bus.valid_i) begin
        s1_q.shift <= in_shift;
`ifdef SHIFTL_ROTATE_EN
        s1_q.rot   <= in_rot;
`endif
        s1_q.shamt <= in_shamt[SHAMT_W-1:SPLIT];
        s1_q.dat   <= lvl1[SPLIT];
      end
    end
  end

  // Remaining high levels work on the registered partial result.
  logic [HI_W:0][WIDTH-1:0] lvl2;
  assign lvl2[0] = s1_q.dat;

  for (genvar g = 0; g < HI_W; g++) begin : g_lvl2
    shiftl_level #(
      .WIDTH (WIDTH),
      .AMT   (1 << (SPLIT + g))
    ) u_lvl (
      .src_dat (lvl2[g]),
      .en      (s1_q.shift && s1_q.shamt[g]),
      .rot     (s1_rot),
      .res_dat (lvl2[g+1])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_q <= '0;
    end else if (s2_load) begin
      s2_q.vld <= s1_q.vld;
      if (s1_q.vld) begin
        s2_q.dat <= lvl2[HI_W];
      end
    end
  end

  assign bus.valid_o = s2_q.vld;
  assign bus.alu_p_o = s2_q.dat;

endmodule
